// File: rtl/buffer_sequencer.sv
// Fill/drain sequencer for the percent-slot buffer: drives slot index, write/read mode and fill level.
// Optional macro BUFFER_SEQUENCER_AUTOLOOP_EN: drain completion loops straight back into FILL.
module buffer_sequencer #(
    parameter int SLOTS       = 10,
    parameter int FILL_TICKS  = 50,
    parameter int DRAIN_TICKS = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       drain_req,
    input  logic       abort,
    output logic [3:0] percent,
    output logic       emptyBuffer,
    output logic [3:0] fill_level,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int MAX_TICKS = (FILL_TICKS > DRAIN_TICKS) ? FILL_TICKS : DRAIN_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_TICKS - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TICKS - 1);
    localparam logic [3:0]    LAST_SLOT  = 4'(SLOTS - 1);
    localparam logic [3:0]    SLOT_COUNT = 4'(SLOTS);

    state_t        state_r;
    logic [3:0]    percent_r;
    logic          empty_r;
    logic [3:0]    level_r;
    logic          full_r;
    logic          busy_r;
    logic          done_r;
    logic [CW-1:0] cnt_r;

    logic fill_tc_s;
    logic drain_tc_s;
    logic last_slot_s;

    assign fill_tc_s   = (cnt_r == FILL_LAST);
    assign drain_tc_s  = (cnt_r == DRAIN_LAST);
    assign last_slot_s = (percent_r == LAST_SLOT);

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            percent_r <= 4'd0;
            empty_r   <= 1'b1;
            level_r   <= 4'd0;
            full_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (abort && (state_r != ST_IDLE)) begin
                state_r   <= ST_IDLE;
                percent_r <= 4'd0;
                empty_r   <= 1'b1;
                level_r   <= 4'd0;
                full_r    <= 1'b0;
                busy_r    <= 1'b0;
                cnt_r     <= {CW{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r <= {CW{1'b0}};
                        if (start && !abort) begin
                            state_r   <= ST_FILL;
                            percent_r <= 4'd0;
                            empty_r   <= 1'b0;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FILL: begin
                        if (fill_tc_s) begin
                            cnt_r <= {CW{1'b0}};
                            if (last_slot_s) begin
                                state_r   <= ST_FULL;
                                percent_r <= 4'd0;
                                empty_r   <= 1'b1;
                                level_r   <= SLOT_COUNT;
                                full_r    <= 1'b1;
                                busy_r    <= 1'b0;
                            end else begin
                                percent_r <= percent_r + 4'd1;
                                level_r   <= level_r + 4'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_FULL: begin
                        cnt_r <= {CW{1'b0}};
                        if (drain_req) begin
                            state_r <= ST_DRAIN;
                            full_r  <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FULL;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_tc_s) begin
                            cnt_r <= {CW{1'b0}};
                            if (last_slot_s) begin
                                percent_r <= 4'd0;
                                level_r   <= 4'd0;
                                done_r    <= 1'b1;
`ifdef BUFFER_SEQUENCER_AUTOLOOP_EN
                                state_r   <= ST_FILL;
                                empty_r   <= 1'b0;
`else
                                state_r   <= ST_IDLE;
                                busy_r    <= 1'b0;
`endif
                            end else begin
                                percent_r <= percent_r + 4'd1;
                                level_r   <= level_r - 4'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        percent_r <= 4'd0;
                        empty_r   <= 1'b1;
                        level_r   <= 4'd0;
                        full_r    <= 1'b0;
                        busy_r    <= 1'b0;
                        cnt_r     <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

    assign state       = state_r;
    assign percent     = percent_r;
    assign emptyBuffer = empty_r;
    assign fill_level  = level_r;
    assign full        = full_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
